vai_rx_route: RTL and testbench
===============================

VAI_RX_ROUTE -- requirements
Module: vai_rx_route

Interface
REQ-001 SHALL have parameter NUM_SUB_AFUS, default 15, number of sub-AFUs served (1..15).
REQ-002 SHALL have port clk, input, 1, single clock for all logic.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port up_RxPort, input, t_if_ccip_Rx, upstream CCI-P Rx from the FIU.
REQ-005 SHALL have port sub_afu_reset, input, [NUM_SUB_AFUS-1:0], per-AFU hold-in-reset flags from the manager AFU.
REQ-006 SHALL have port afu_RxPort, output, t_if_ccip_Rx [NUM_SUB_AFUS-1:0], per-AFU Rx.
REQ-007 SHALL have port mgr_RxPort, output, t_if_ccip_Rx, manager AFU Rx.
REQ-008 SHALL have port drop_count, output, 16, saturating count of discarded messages.
REQ-009 SHALL have port err_count, output, 16, saturating count of messages with an illegal tag or MMIO window.

Function
REQ-010 SHALL define tag = hdr.mdata[15:12] for c0 read responses and c1 write/fence/interrupt responses.
REQ-011 SHALL route a response with tag < NUM_SUB_AFUS to afu_RxPort[tag] and with tag == NUM_SUB_AFUS to mgr_RxPort.
REQ-012 SHALL treat a response with tag > NUM_SUB_AFUS as illegal: not forwarded, err_count +1.
REQ-013 SHALL clear mdata[15:12] to 0 in every forwarded response header; all other header and data bits unchanged.
REQ-014 SHALL define MMIO window index w = mmio address[13:8] for c0 mmioRdValid/mmioWrValid.
REQ-015 SHALL route MMIO with w == 0 to mgr_RxPort and 1 <= w <= NUM_SUB_AFUS to afu_RxPort[w-1], subtracting w<<8 from the address.
REQ-016 SHALL treat MMIO with w > NUM_SUB_AFUS as illegal: not forwarded, err_count +1.
REQ-017 SHALL discard any response or MMIO request whose destination AFU i has sub_afu_reset[i]=1, sampled in the decode cycle; drop_count +1; the manager is never dropped.
REQ-018 SHALL use a fixed 2-cycle latency: stage 1 registers up_RxPort and decodes; stage 2 registers the outputs.
REQ-019 SHALL assert at most one valid per channel per cycle across all outputs; all non-destination outputs carry valid=0 that cycle.
REQ-020 SHALL handle c0 and c1 independently; a c0 and a c1 message in the same cycle may target different outputs.
REQ-021 SHALL broadcast c0TxAlmFull and c1TxAlmFull to every output with the same 2-cycle latency.
REQ-022 SHALL increment a counter by 2 when both channels hit the same counter event in one cycle, saturating at 0xFFFF with no wrap.
REQ-023 SHALL accept back-to-back messages every cycle with no stall and no backpressure.

Reset
REQ-024 SHALL clear all valid bits, both pipeline stages, drop_count and err_count to 0 while reset=1, independent of clk.
REQ-025 SHALL drive c0TxAlmFull=c1TxAlmFull=1 on all outputs during reset and for the first 2 cycles after deassertion.
REQ-026 SHALL lose any message in flight at reset assertion; nothing is replayed after reset.

Verification
REQ-027 SHALL pass this scenario: c0 rspValid with mdata=0x3ABC, NUM=15 -> afu_RxPort[3] rspValid at cycle +2 with mdata=0x0ABC; all other outputs invalid.
REQ-028 SHALL pass this scenario: mmioWr at address 0x0210 -> afu_RxPort[1] mmioWrValid at +2 with address 0x0010; the same write at 0x0010 -> mgr_RxPort.
REQ-029 SHALL pass this scenario: NUM=5, c1 response tag 7 -> no output valid and err_count=1; tag 5 -> mgr_RxPort.
REQ-030 SHALL pass this scenario: sub_afu_reset[2]=1 with 3 responses tagged 2 -> none forwarded and drop_count=3; after deassertion the next tag-2 response is forwarded.
REQ-031 SHALL pass this scenario: c0 and c1 illegal in the same cycle with err_count=0xFFFE -> err_count=0xFFFF and it stays there on further errors.
REQ-032 SHALL pass this scenario: reset asserted mid-stream -> outputs invalid immediately, counters 0, AlmFull=1 until 2 cycles after release.

Source files
------------

// File: rtl/vai_rx_route.sv
// vai_rx_route: steers the upstream CCI-P Rx stream to one of NUM_SUB_AFUS
// sub-AFUs or to the manager AFU.
//   clk           - single clock
//   reset         - asynchronous, active-high
//   up_RxPort     - CCI-P Rx from the FIU
//   sub_afu_reset - per-AFU hold-in-reset flags; messages to a held AFU are discarded
//   afu_RxPort    - per-AFU Rx, tag / MMIO window stripped
//   mgr_RxPort    - manager AFU Rx
//   drop_count    - saturating count of messages discarded for a held AFU
//   err_count     - saturating count of messages with an illegal tag or MMIO window
// Latency is fixed at two cycles: stage 1 registers the decoded input,
// stage 2 registers the per-destination outputs.

package vai_rx_route_pkg;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic [1:0]  rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c0_RspMemHdr;

    // MMIO request view of the same 28 header bits.
    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic        format;
        logic        rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        logic [511:0]       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

endpackage

module vai_rx_route
    import vai_rx_route_pkg::*;
#(
    parameter int unsigned NUM_SUB_AFUS = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  t_if_ccip_Rx             up_RxPort,
    input  logic [NUM_SUB_AFUS-1:0] sub_afu_reset,
    output t_if_ccip_Rx             afu_RxPort [NUM_SUB_AFUS],
    output t_if_ccip_Rx             mgr_RxPort,
    output logic [15:0]             drop_count,
    output logic [15:0]             err_count
);

    localparam int unsigned DW = 4;
    localparam int unsigned RXW = $bits(t_if_ccip_Rx);
    // Destination code NUM_SUB_AFUS means the manager.
    localparam logic [DW-1:0] MGR = DW'(NUM_SUB_AFUS);
    // Idle word: no valids, both AlmFull flags raised (they are the two MSBs).
    localparam t_if_ccip_Rx RX_IDLE = t_if_ccip_Rx'({2'b11, {(RXW - 2){1'b0}}});

    // True when destination idx is a sub-AFU currently held in reset.
    function automatic logic afu_held(input logic [DW-1:0] idx,
                                      input logic [NUM_SUB_AFUS-1:0] held);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SUB_AFUS; i++) begin
            if (idx == DW'(i)) hit = held[i];
        end
        return hit;
    endfunction

    // Add up to two events, clamping at 0xFFFF.
    function automatic logic [15:0] sat_add(input logic [15:0] cnt,
                                            input logic a, input logic b);
        logic [16:0] sum;
        sum = {1'b0, cnt} + 17'(a) + 17'(b);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Decode signals
    t_if_ccip_c0_Rx      c0_pay;
    t_if_ccip_c1_Rx      c1_pay;
    t_ccip_c0_ReqMmioHdr mmio_hdr;
    logic [5:0]          mmio_win;
    logic [DW-1:0]       c0_tag, c1_tag;
    logic [DW-1:0]       c0_dst, c1_dst;
    logic                c0_any, c0_legal, c0_err, c0_drop, c0_fwd;
    logic                c1_legal, c1_err, c1_drop, c1_fwd;

    // Stage 1 registers
    t_if_ccip_Rx   s1_rx;
    logic [DW-1:0] s1_c0_dst, s1_c1_dst;
    logic          s1_c0_fwd, s1_c0_err, s1_c0_drop;
    logic          s1_c1_fwd, s1_c1_err, s1_c1_drop;

    // Stage 2 next values
    t_if_ccip_Rx afu_nxt [NUM_SUB_AFUS];
    t_if_ccip_Rx mgr_nxt;

    // c0 decode: responses by tag, MMIO by address window.
    always_comb begin
        c0_pay   = up_RxPort.c0;
        c0_any   = up_RxPort.c0.rspValid | up_RxPort.c0.mmioRdValid | up_RxPort.c0.mmioWrValid;
        c0_tag   = up_RxPort.c0.hdr.mdata[15:12];
        mmio_hdr = t_ccip_c0_ReqMmioHdr'(up_RxPort.c0.hdr);
        mmio_win = mmio_hdr.address[13:8];
        c0_dst   = '0;
        c0_legal = 1'b0;
        if (up_RxPort.c0.rspValid) begin
            c0_pay.hdr.mdata[15:12] = '0;
            c0_legal = (32'(c0_tag) <= NUM_SUB_AFUS);
            c0_dst   = c0_tag;
        end else if (up_RxPort.c0.mmioRdValid || up_RxPort.c0.mmioWrValid) begin
            c0_legal = (32'(mmio_win) <= NUM_SUB_AFUS);
            c0_dst   = (mmio_win == 6'd0) ? MGR : DW'(mmio_win - 6'd1);
            // Rebase the address into the target AFU's own window.
            mmio_hdr.address = mmio_hdr.address - {2'b00, mmio_win, 8'h00};
            c0_pay.hdr = t_ccip_c0_RspMemHdr'(mmio_hdr);
        end
        c0_err  = c0_any & ~c0_legal;
        c0_drop = c0_any & c0_legal & (c0_dst != MGR) & afu_held(c0_dst, sub_afu_reset);
        c0_fwd  = c0_any & c0_legal & ~c0_drop;
    end

    // c1 decode: responses by tag only.
    always_comb begin
        c1_pay   = up_RxPort.c1;
        c1_tag   = up_RxPort.c1.hdr.mdata[15:12];
        c1_pay.hdr.mdata[15:12] = '0;
        c1_dst   = c1_tag;
        c1_legal = (32'(c1_tag) <= NUM_SUB_AFUS);
        c1_err   = up_RxPort.c1.rspValid & ~c1_legal;
        c1_drop  = up_RxPort.c1.rspValid & c1_legal & (c1_dst != MGR) & afu_held(c1_dst, sub_afu_reset);
        c1_fwd   = up_RxPort.c1.rspValid & c1_legal & ~c1_drop;
    end

    // Stage 1: capture rewritten payload and routing decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_rx      <= RX_IDLE;
            s1_c0_dst  <= '0;
            s1_c0_fwd  <= 1'b0;
            s1_c0_err  <= 1'b0;
            s1_c0_drop <= 1'b0;
            s1_c1_dst  <= '0;
            s1_c1_fwd  <= 1'b0;
            s1_c1_err  <= 1'b0;
            s1_c1_drop <= 1'b0;
        end else begin
            s1_rx.c0TxAlmFull <= up_RxPort.c0TxAlmFull;
            s1_rx.c1TxAlmFull <= up_RxPort.c1TxAlmFull;
            s1_rx.c0          <= c0_pay;
            s1_rx.c1          <= c1_pay;
            s1_c0_dst  <= c0_dst;
            s1_c0_fwd  <= c0_fwd;
            s1_c0_err  <= c0_err;
            s1_c0_drop <= c0_drop;
            s1_c1_dst  <= c1_dst;
            s1_c1_fwd  <= c1_fwd;
            s1_c1_err  <= c1_err;
            s1_c1_drop <= c1_drop;
        end
    end

    // Fan the stage-1 word out; only the chosen destination keeps its valids.
    always_comb begin
        mgr_nxt = s1_rx;
        mgr_nxt.c0.rspValid    = s1_rx.c0.rspValid    & s1_c0_fwd & (s1_c0_dst == MGR);
        mgr_nxt.c0.mmioRdValid = s1_rx.c0.mmioRdValid & s1_c0_fwd & (s1_c0_dst == MGR);
        mgr_nxt.c0.mmioWrValid = s1_rx.c0.mmioWrValid & s1_c0_fwd & (s1_c0_dst == MGR);
        mgr_nxt.c1.rspValid    = s1_rx.c1.rspValid    & s1_c1_fwd & (s1_c1_dst == MGR);
        for (int unsigned i = 0; i < NUM_SUB_AFUS; i++) begin
            afu_nxt[i] = s1_rx;
            afu_nxt[i].c0.rspValid    = s1_rx.c0.rspValid    & s1_c0_fwd & (s1_c0_dst == DW'(i));
            afu_nxt[i].c0.mmioRdValid = s1_rx.c0.mmioRdValid & s1_c0_fwd & (s1_c0_dst == DW'(i));
            afu_nxt[i].c0.mmioWrValid = s1_rx.c0.mmioWrValid & s1_c0_fwd & (s1_c0_dst == DW'(i));
            afu_nxt[i].c1.rspValid    = s1_rx.c1.rspValid    & s1_c1_fwd & (s1_c1_dst == DW'(i));
        end
    end

    // Stage 2: registered outputs and event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SUB_AFUS; i++) begin
                afu_RxPort[i] <= RX_IDLE;
            end
            mgr_RxPort <= RX_IDLE;
            drop_count <= '0;
            err_count  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SUB_AFUS; i++) begin
                afu_RxPort[i] <= afu_nxt[i];
            end
            mgr_RxPort <= mgr_nxt;
            drop_count <= sat_add(drop_count, s1_c0_drop, s1_c1_drop);
            err_count  <= sat_add(err_count, s1_c0_err, s1_c1_err);
        end
    end

endmodule

// File: tb/tb_vai_rx_route.sv
// Randomised scoreboard bench for vai_rx_route (NUM_SUB_AFUS = 5).
module tb_vai_rx_route;
    import vai_rx_route_pkg::*;

    localparam int NUM  = 5;
    localparam int MAXC = 40000;

    typedef struct {
        int           due;
        int           dest;
        logic [2:0]   vld;
        logic [27:0]  hdr;
        logic [511:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    t_if_ccip_Rx       up_rx = '0;
    logic [NUM-1:0]    sub_rst = '0;
    t_if_ccip_Rx       afu_rx [NUM];
    t_if_ccip_Rx       mgr_rx;
    logic [15:0]       drop_count, err_count;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   m_err = 0;
    int   m_drop = 0;
    int   err_inc  [0:MAXC-1];
    int   drop_inc [0:MAXC-1];
    logic [1:0] alm_hist [0:MAXC-1];
    exp_t q0[$];
    exp_t q1[$];
    t_if_ccip_Rx mo;

    vai_rx_route #(.NUM_SUB_AFUS(NUM)) dut (
        .clk          (clk),
        .reset        (rst),
        .up_RxPort    (up_rx),
        .sub_afu_reset(sub_rst),
        .afu_RxPort   (afu_rx),
        .mgr_RxPort   (mgr_rx),
        .drop_count   (drop_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic t_if_ccip_Rx out_of(input int d);
        return (d == NUM) ? mgr_rx : afu_rx[d];
    endfunction

    // Reference decision: push an expected output, or book an error / drop.
    task automatic book(input int ch, input bit legal, input int dst,
                        input logic [NUM-1:0] ar, input exp_t e);
        int k;
        k = cyc + 2;
        if (!legal) begin
            if (k < MAXC) err_inc[k]++;
        end else if (dst < NUM && ar[dst]) begin
            if (k < MAXC) drop_inc[k]++;
        end else begin
            e.due  = k;
            e.dest = dst;
            if (ch == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    // One clock of stimulus. c0k: 0 none, 1 rsp, 2 mmioRd, 3 mmioWr.
    task automatic issue(input int c0k, input logic [27:0] h0, input logic [511:0] d0,
                         input bit v1, input logic [27:0] h1,
                         input logic [NUM-1:0] ar, input logic [1:0] alm);
        exp_t e;
        int   tg, addr, w;
        @(posedge clk);
        #1;
        rst = 1'b0;
        up_rx = '0;
        up_rx.c0TxAlmFull = alm[1];
        up_rx.c1TxAlmFull = alm[0];
        up_rx.c0.hdr  = t_ccip_c0_RspMemHdr'(h0);
        up_rx.c0.data = d0;
        up_rx.c0.rspValid    = (c0k == 1);
        up_rx.c0.mmioRdValid = (c0k == 2);
        up_rx.c0.mmioWrValid = (c0k == 3);
        up_rx.c1.hdr  = t_ccip_c1_RspMemHdr'(h1);
        up_rx.c1.rspValid = v1;
        sub_rst = ar;
        if (cyc < MAXC) alm_hist[cyc] = alm;
        if (c0k != 0) begin
            e.vld  = (c0k == 1) ? 3'b100 : (c0k == 2) ? 3'b010 : 3'b001;
            e.data = d0;
            if (c0k == 1) begin
                tg    = int'((h0 >> 12) & 28'hF);
                e.hdr = h0 & ~(28'hF << 12);
                book(0, tg <= NUM, tg, ar, e);
            end else begin
                addr  = int'(h0 >> 12);
                w     = (addr / 256) % 64;
                e.hdr = {16'(addr - w * 256), h0[11:0]};
                book(0, w <= NUM, (w == 0) ? NUM : w - 1, ar, e);
            end
        end
        if (v1) begin
            tg     = int'((h1 >> 12) & 28'hF);
            e.vld  = 3'b100;
            e.data = '0;
            e.hdr  = h1 & ~(28'hF << 12);
            book(1, tg <= NUM, tg, ar, e);
        end
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            up_rx = '0;
            if (cyc < MAXC) alm_hist[cyc] = 2'b11;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(0, '0, '0, 1'b0, '0, sub_rst, 2'b00);
    endtask

    function automatic int pick(input int hi_legal, input int hi_any);
        return ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, hi_legal))
                                           : int'($urandom_range(0, hi_any));
    endfunction

    task automatic rand_cycle(input bit bad, input logic [NUM-1:0] ar);
        int           k0;
        logic [27:0]  h0, h1;
        logic [511:0] d;
        bit           v1;
        for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom();
        h0 = 28'($urandom());
        h1 = 28'($urandom());
        k0 = bad ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
        if (k0 == 1)
            h0[15:12] = 4'(bad ? int'($urandom_range(NUM + 1, 15)) : pick(NUM, 15));
        else if (k0 >= 2)
            h0[25:20] = 6'(bad ? int'($urandom_range(NUM + 1, 63)) : pick(NUM, 63));
        v1 = bad ? 1'b1 : 1'($urandom_range(0, 1));
        h1[15:12] = 4'(bad ? int'($urandom_range(NUM + 1, 15)) : pick(NUM, 15));
        issue(k0, h0, d, v1, h1, ar, bad ? 2'b00 : 2'($urandom()));
    endtask

    // Monitor: checks whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin
        int n0, n1, d0, d1, inc;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_err  = 0;
            m_drop = 0;
            n0 = 0;
            for (int i = 0; i <= NUM; i++) begin
                mo = out_of(i);
                n0 += int'(mo.c0.rspValid) + int'(mo.c0.mmioRdValid)
                    + int'(mo.c0.mmioWrValid) + int'(mo.c1.rspValid);
                chk("rst_almfull", {mo.c0TxAlmFull, mo.c1TxAlmFull}, 2'b11);
            end
            chk("rst_valids", n0, 0);
            chk("rst_err_count", err_count, 0);
            chk("rst_drop_count", drop_count, 0);
        end else begin
            n0 = 0; n1 = 0; d0 = 0; d1 = 0;
            for (int i = 0; i <= NUM; i++) begin
                mo = out_of(i);
                if (mo.c0.rspValid | mo.c0.mmioRdValid | mo.c0.mmioWrValid) begin n0++; d0 = i; end
                if (mo.c1.rspValid) begin n1++; d1 = i; end
                if (cyc >= 2 && cyc < MAXC + 2)
                    chk("almfull", {mo.c0TxAlmFull, mo.c1TxAlmFull}, alm_hist[cyc-2]);
            end
            chk("c0_at_most_one", n0 > 1, 0);
            chk("c1_at_most_one", n1 > 1, 0);
            while (q0.size() > 0 && q0[0].due < cyc) begin
                chk("c0_missing", cyc, q0[0].due);
                void'(q0.pop_front());
            end
            while (q1.size() > 0 && q1[0].due < cyc) begin
                chk("c1_missing", cyc, q1[0].due);
                void'(q1.pop_front());
            end
            if (n0 > 0) begin
                chk("c0_expected", q0.size() > 0, 1);
                if (q0.size() > 0) begin
                    exp_t e;
                    e  = q0.pop_front();
                    mo = out_of(d0);
                    chk("c0_cycle", cyc, e.due);
                    chk("c0_dest", d0, e.dest);
                    chk("c0_kind", {mo.c0.rspValid, mo.c0.mmioRdValid, mo.c0.mmioWrValid}, e.vld);
                    chk("c0_hdr", 28'(mo.c0.hdr), e.hdr);
                    chk("c0_data", mo.c0.data, e.data);
                end
            end
            if (n1 > 0) begin
                chk("c1_expected", q1.size() > 0, 1);
                if (q1.size() > 0) begin
                    exp_t e;
                    e  = q1.pop_front();
                    mo = out_of(d1);
                    chk("c1_cycle", cyc, e.due);
                    chk("c1_dest", d1, e.dest);
                    chk("c1_hdr", 28'(mo.c1.hdr), e.hdr);
                end
            end
            inc = (cyc < MAXC) ? err_inc[cyc] : 0;
            m_err = (m_err + inc > 65535) ? 65535 : m_err + inc;
            inc = (cyc < MAXC) ? drop_inc[cyc] : 0;
            m_drop = (m_drop + inc > 65535) ? 65535 : m_drop + inc;
            chk("err_count", err_count, m_err);
            chk("drop_count", drop_count, m_drop);
        end
    end

    initial begin
        #(MAXC * 10 + 1000);
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [511:0]   d;
        logic [NUM-1:0] ar;
        for (int i = 0; i < MAXC; i++) alm_hist[i] = 2'b11;
        for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom();
        reset_cycles(3);

        // Directed routing scenarios.
        issue(1, 28'h0003ABC, d, 1'b0, '0, '0, 2'b00);              // afu[3], mdata 0x0ABC
        issue(3, {16'h0210, 12'h5A5}, d, 1'b0, '0, '0, 2'b01);      // afu[1], addr 0x0010
        issue(3, {16'h0010, 12'h5A5}, d, 1'b0, '0, '0, 2'b10);      // manager
        issue(0, '0, d, 1'b1, 28'h0007123, '0, 2'b00);              // tag 7: illegal
        issue(0, '0, d, 1'b1, 28'h0005123, '0, 2'b00);              // tag 5: manager
        for (int i = 0; i < 3; i++)
            issue(0, '0, d, 1'b1, 28'h0002000 + 28'(i), 5'b00100, 2'b00);
        issue(0, '0, d, 1'b1, 28'h0002FFF, 5'b00000, 2'b00);        // forwarded again
        idle(3);
        chk("directed_err_count", err_count, 16'd1);
        chk("directed_drop_count", drop_count, 16'd3);

        // Random traffic with a mid-stream reset.
        ar = '0;
        for (int i = 0; i < 2500; i++) begin
            if (($urandom() & 15) == 0) ar = NUM'($urandom() & $urandom());
            if (i == 1200) begin
                reset_cycles(3);
                chk("midrst_err_count", err_count, 16'd0);
            end
            rand_cycle(1'b0, ar);
        end
        idle(3);

        // Counter saturation: two errors per cycle.
        reset_cycles(2);
        for (int i = 0; i < 32767; i++) rand_cycle(1'b1, '0);
        idle(2);
        chk("sat_err_fffe", err_count, 16'hFFFE);
        rand_cycle(1'b1, '0);
        idle(2);
        chk("sat_err_ffff", err_count, 16'hFFFF);
        for (int i = 0; i < 3; i++) rand_cycle(1'b1, '0);
        idle(3);
        chk("sat_err_hold", err_count, 16'hFFFF);
        chk("c0_queue_drained", q0.size(), 0);
        chk("c1_queue_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
